// File: rtl/uart_denetleyici_pkg.sv
// Shared types and helpers for the UART controller; constants come from uart_sabitler.vh.
package uart_denetleyici_pkg;
  `include "uart_sabitler.vh"

  typedef enum logic {
    TX_BOSTA  = TX_BOSTA_KOD,
    TX_GONDER = TX_GONDER_KOD
  } tx_durum_t;

  function automatic logic [31:0] durum_paketle(input logic rx_bos, input logic rx_dolu,
                                                input logic tx_bos, input logic tx_dolu,
                                                input logic rx_tasma, input logic [3:0] rx_sayi);
    logic [31:0] d;
    d = '0;
    d[DURUM_RX_BOS]               = rx_bos;
    d[DURUM_RX_DOLU]              = rx_dolu;
    d[DURUM_TX_BOS]               = tx_bos;
    d[DURUM_TX_DOLU]              = tx_dolu;
    d[DURUM_RX_TASMA]             = rx_tasma;
    d[DURUM_RX_SAYI_LSB +: 4]     = rx_sayi;
    return d;
  endfunction
endpackage

// File: rtl/uart_denetleyici_if.sv
// Register bus of the UART controller: one-cycle request, response exactly one cycle later, never stalls.
interface uart_denetleyici_if;
  logic        istek_gecerli_i;
  logic        istek_yaz_i;
  logic [4:0]  istek_adres_i;
  logic [31:0] istek_veri_i;
  logic        yanit_gecerli_o;
  logic [31:0] yanit_veri_o;

  modport master (
    output istek_gecerli_i, istek_yaz_i, istek_adres_i, istek_veri_i,
    input  yanit_gecerli_o, yanit_veri_o
  );

  modport slave (
    input  istek_gecerli_i, istek_yaz_i, istek_adres_i, istek_veri_i,
    output yanit_gecerli_o, yanit_veri_o
  );
endinterface

// File: rtl/uart_kuyruk.sv
// Synchronous byte FIFO; head visible combinationally, push/pop take effect on the next edge.
// A push while full is accepted only if a pop happens in the same cycle; pop on empty is ignored.
module uart_kuyruk #(
  parameter int DERINLIK = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 veri_gir,
  output logic [7:0]                 veri_cik,
  output logic                       bos,
  output logic                       dolu,
  output logic [$clog2(DERINLIK):0]  sayi
);
  localparam int AW = $clog2(DERINLIK);
  localparam int SW = AW + 1;

  logic [7:0]    mem [DERINLIK];
  logic [AW-1:0] yaz_ptr, oku_ptr;
  logic          yaz, oku;

  assign bos      = (sayi == '0);
  assign dolu     = (sayi == SW'(DERINLIK));
  assign yaz      = push & (~dolu | pop);
  assign oku      = pop & ~bos;
  assign veri_cik = mem[oku_ptr];

  always_ff @(posedge clk_i) begin
    if (yaz) mem[yaz_ptr] <= veri_gir;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (yaz) yaz_ptr <= yaz_ptr + AW'(1);
      if (oku) oku_ptr <= oku_ptr + AW'(1);
      case ({yaz, oku})
        2'b10:   sayi <= sayi + SW'(1);
        2'b01:   sayi <= sayi - SW'(1);
        default: sayi <= sayi;
      endcase
    end
  end
endmodule

// File: rtl/uart_sabitler.vh
// Shared register offsets, DURUM/KONTROL bit positions and TX state codes for the UART controller.
`ifndef UART_SABITLER_VH
`define UART_SABITLER_VH

localparam logic [4:0] ADR_BAUD    = 5'h00;
localparam logic [4:0] ADR_DURUM   = 5'h04;
localparam logic [4:0] ADR_RXVERI  = 5'h08;
localparam logic [4:0] ADR_TXVERI  = 5'h0C;
localparam logic [4:0] ADR_KONTROL = 5'h10;

localparam int DURUM_RX_BOS      = 0;
localparam int DURUM_RX_DOLU     = 1;
localparam int DURUM_TX_BOS      = 2;
localparam int DURUM_TX_DOLU     = 3;
localparam int DURUM_RX_TASMA    = 4;
localparam int DURUM_RX_SAYI_LSB = 8;

localparam int KONTROL_RX_EN       = 0;
localparam int KONTROL_TX_EN       = 1;
localparam int KONTROL_TASMA_SIL   = 2;
localparam int KONTROL_KESME_MASKE = 3;

localparam logic TX_BOSTA_KOD  = 1'b0;
localparam logic TX_GONDER_KOD = 1'b1;

`endif

// File: rtl/uart_denetleyici.sv
// UART register controller: RX/TX byte queues, baud register, TX handoff FSM; responses 1 cycle after request, no bus backpressure.
// Optional interrupt output kesme_o is built in when UART_KESME_EN is defined.
module uart_denetleyici
  import uart_denetleyici_pkg::*;
#(
  parameter int          FIFO_DERINLIK   = 8,
  parameter logic [15:0] BAUD_VARSAYILAN = 16'd868
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  uart_denetleyici_if.slave    bus,
  output logic [15:0]          baud_div_o,
  input  logic [7:0]           rx_veri_i,
  input  logic                 rx_gecerli_i,
  output logic [7:0]           tx_veri_o,
  output logic                 tx_gecerli_o,
  input  logic                 tx_hazir_i
`ifdef UART_KESME_EN
  ,
  output logic                 kesme_o
`endif
);
  localparam int SW = $clog2(FIFO_DERINLIK) + 1;

  logic          yaz_istek, oku_istek;
  logic          rx_en, tx_en, rx_tasma;
  logic          rx_push, rx_pop, rx_bos, rx_dolu, tasma_olay;
  logic          tx_push, tx_pop, tx_bos, tx_dolu;
  logic [7:0]    rx_bas, tx_bas;
  logic [SW-1:0] rx_sayi, tx_sayi;
  logic [31:0]   okuma_verisi, kontrol_oku;
  tx_durum_t     tx_durum;
  logic          unused_ok;

  assign yaz_istek = bus.istek_gecerli_i & bus.istek_yaz_i;
  assign oku_istek = bus.istek_gecerli_i & ~bus.istek_yaz_i;
  assign unused_ok = &{1'b0, bus.istek_veri_i[31:16], tx_sayi};

  // A simultaneous pop frees the slot, so a full queue still takes the byte without overflow.
  assign rx_pop     = oku_istek & (bus.istek_adres_i == ADR_RXVERI) & ~rx_bos;
  assign rx_push    = rx_gecerli_i & rx_en;
  assign tasma_olay = rx_gecerli_i & rx_en & rx_dolu & ~rx_pop;
  assign tx_push    = yaz_istek & (bus.istek_adres_i == ADR_TXVERI) & ~tx_dolu;
  assign tx_pop     = (tx_durum == TX_BOSTA) & tx_en & ~tx_bos;

  uart_kuyruk #(.DERINLIK(FIFO_DERINLIK)) u_rx_kuyruk (
    .clk_i(clk_i), .rstn_i(rstn_i), .push(rx_push), .pop(rx_pop), .veri_gir(rx_veri_i),
    .veri_cik(rx_bas), .bos(rx_bos), .dolu(rx_dolu), .sayi(rx_sayi)
  );

  uart_kuyruk #(.DERINLIK(FIFO_DERINLIK)) u_tx_kuyruk (
    .clk_i(clk_i), .rstn_i(rstn_i), .push(tx_push), .pop(tx_pop), .veri_gir(bus.istek_veri_i[7:0]),
    .veri_cik(tx_bas), .bos(tx_bos), .dolu(tx_dolu), .sayi(tx_sayi)
  );

`ifdef UART_KESME_EN
  logic kesme_maske;
`endif

  always_comb begin
    kontrol_oku = '0;
    kontrol_oku[KONTROL_RX_EN] = rx_en;
    kontrol_oku[KONTROL_TX_EN] = tx_en;
`ifdef UART_KESME_EN
    kontrol_oku[KONTROL_KESME_MASKE] = kesme_maske;
`endif
  end

  always_comb begin
    okuma_verisi = '0;
    case (bus.istek_adres_i)
      ADR_BAUD:    okuma_verisi = {16'h0000, baud_div_o};
      ADR_DURUM:   okuma_verisi = durum_paketle(rx_bos, rx_dolu, tx_bos, tx_dolu, rx_tasma, 4'(rx_sayi));
      ADR_RXVERI:  okuma_verisi = rx_bos ? 32'h0 : {24'h0, rx_bas};
      ADR_KONTROL: okuma_verisi = kontrol_oku;
      default:     okuma_verisi = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus.yanit_gecerli_o <= 1'b0;
      bus.yanit_veri_o    <= '0;
    end else begin
      bus.yanit_gecerli_o <= bus.istek_gecerli_i;
      bus.yanit_veri_o    <= oku_istek ? okuma_verisi : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      baud_div_o <= BAUD_VARSAYILAN;
      rx_en      <= 1'b0;
      tx_en      <= 1'b0;
      rx_tasma   <= 1'b0;
`ifdef UART_KESME_EN
      kesme_maske <= 1'b0;
`endif
    end else begin
      // Divisors of 0 and 1 cannot produce a bit period, so those writes leave BAUD untouched.
      if (yaz_istek && bus.istek_adres_i == ADR_BAUD && bus.istek_veri_i[15:0] > 16'd1)
        baud_div_o <= bus.istek_veri_i[15:0];
      if (yaz_istek && bus.istek_adres_i == ADR_KONTROL) begin
        rx_en <= bus.istek_veri_i[KONTROL_RX_EN];
        tx_en <= bus.istek_veri_i[KONTROL_TX_EN];
`ifdef UART_KESME_EN
        kesme_maske <= bus.istek_veri_i[KONTROL_KESME_MASKE];
`endif
        if (bus.istek_veri_i[KONTROL_TASMA_SIL]) rx_tasma <= 1'b0;
      end
      if (tasma_olay) rx_tasma <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_durum     <= TX_BOSTA;
      tx_gecerli_o <= 1'b0;
      tx_veri_o    <= '0;
    end else begin
      case (tx_durum)
        TX_BOSTA: if (tx_pop) begin
          tx_veri_o    <= tx_bas;
          tx_gecerli_o <= 1'b1;
          tx_durum     <= TX_GONDER;
        end
        TX_GONDER: if (tx_hazir_i) begin
          tx_gecerli_o <= 1'b0;
          tx_durum     <= TX_BOSTA;
        end
        default: tx_durum <= TX_BOSTA;
      endcase
    end
  end

`ifdef UART_KESME_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) kesme_o <= 1'b0;
    else         kesme_o <= kesme_maske & ((rx_en & ~rx_bos) | rx_tasma);
  end
`endif
endmodule

// File: doc/uart_denetleyici.md
UART_DENETLEYICI -- requirements
Module: uart_denetleyici

Interface
REQ-001 SHALL have parameter FIFO_DERINLIK, default 8, power of two, depth of each of the RX and TX queues.
REQ-002 SHALL have parameter BAUD_VARSAYILAN, default 16'd868, reset value of the baud divisor register.
REQ-003 SHALL have port clk_i  input  1  the single clock; all flops on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port istek_gecerli_i  input  1  bus request valid.
REQ-006 SHALL have port istek_yaz_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port istek_adres_i  input  5  byte offset into the register map.
REQ-008 SHALL have port istek_veri_i  input  32  write data.
REQ-009 SHALL have port yanit_gecerli_o  output  1  response valid pulse.
REQ-010 SHALL have port yanit_veri_o  output  32  read data, zero on writes.
REQ-011 SHALL have port baud_div_o  output  16  divisor driven to the receiver and transmitter.
REQ-012 SHALL have port rx_veri_i  input  8  received byte from the receiver.
REQ-013 SHALL have port rx_gecerli_i  input  1  one-cycle pulse qualifying rx_veri_i.
REQ-014 SHALL have port tx_veri_o  output  8  byte offered to the transmitter.
REQ-015 SHALL have port tx_gecerli_o  output  1  tx_veri_o valid.
REQ-016 SHALL have port tx_hazir_i  input  1  transmitter accepts; a transfer completes when tx_gecerli_o and tx_hazir_i are both high on a rising edge.

Function
REQ-017 SHALL decode this register map: 0x00 BAUD (RW, [15:0]); 0x04 DURUM (RO); 0x08 RXVERI (RO, pops); 0x0C TXVERI (WO, pushes); 0x10 KONTROL (RW).
REQ-018 SHALL lay out DURUM as: bit0 rx_bos, bit1 rx_dolu, bit2 tx_bos, bit3 tx_dolu, bit4 rx_tasma (sticky), bits[11:8] rx_sayi.
REQ-019 SHALL lay out KONTROL as: bit0 rx_en, bit1 tx_en; a write of 1 to bit2 clears rx_tasma (self-clearing, reads 0).
REQ-020 SHALL raise yanit_gecerli_o exactly one cycle after each accepted istek_gecerli_i; every request is accepted, so there is no backpressure.
REQ-021 SHALL return rx_veri_i's FIFO head zero-extended on a RXVERI read and pop it in the same cycle; a read when empty returns 0 and does not pop.
REQ-022 SHALL push istek_veri_i[7:0] into the TX FIFO on a TXVERI write; a write when full is dropped with no other effect.
REQ-023 SHALL push rx_veri_i on rx_gecerli_i when rx_en=1; when full or rx_en=0 the byte is dropped, and if full with rx_en=1 rx_tasma is set.
REQ-024 SHALL, on the same cycle as a pop and an rx push with the FIFO full, accept the push without setting rx_tasma.
REQ-025 SHALL implement the TX FSM with states TX_BOSTA and TX_GONDER: TX_BOSTA goes to TX_GONDER when tx_en=1 and the TX FIFO is non-empty, latching the head into tx_veri_o and popping; TX_GONDER holds tx_gecerli_o=1 with stable data until tx_hazir_i, then returns to TX_BOSTA.
REQ-026 SHALL let a byte already in TX_GONDER complete even if tx_en is cleared.
REQ-027 SHALL reject a BAUD write of 0 or 1 (register unchanged); baud_div_o changes one cycle after an accepted write.
REQ-028 SHALL read unmapped addresses as 0 and ignore writes to them and to RO registers.

Reset
REQ-029 SHALL on rstn_i low set: both FIFOs empty, rx_tasma=0, KONTROL=0, BAUD=BAUD_VARSAYILAN, TX FSM=TX_BOSTA, yanit_gecerli_o=0, yanit_veri_o=0, tx_gecerli_o=0, tx_veri_o=0.
REQ-030 SHALL discard an in-flight TX byte and a pending response when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, when UART_KESME_EN is defined, add output kesme_o (1 bit, registered) = (rx_en & ~rx_bos) | rx_tasma, plus KONTROL bit3 kesme_maske gating it; kesme_o resets to 0.
REQ-032 SHALL, when UART_KESME_EN is undefined, have no kesme_o port, and KONTROL bit3 reads 0.

Structure
REQ-033 SHALL place register offsets, DURUM/KONTROL bit indices and TX state encodings in the shared header uart_sabitler.vh.
REQ-034 SHALL instantiate sub-module uart_kuyruk (synchronous FIFO with push, pop, bos, dolu and sayi) twice, once for RX and once for TX.

Verification
REQ-035 SHALL cover: write KONTROL=0x1, pulse rx 0xA5 then 0x3C, then read RXVERI twice -> returns 0xA5 then 0x3C, and DURUM.rx_bos=1 afterwards.
REQ-036 SHALL cover: rx_en=1, 9 rx pulses with no reads -> rx_sayi=8 and rx_tasma=1; then write KONTROL=0x5 -> rx_tasma=0.
REQ-037 SHALL cover: tx_en=1, write TXVERI 0x55 with tx_hazir_i held low 5 cycles -> tx_gecerli_o high and tx_veri_o=0x55 stable until tx_hazir_i, then tx_gecerli_o=0.
REQ-038 SHALL cover: write BAUD=1 -> BAUD reads back 868; write BAUD=434 -> baud_div_o=434 next cycle.
REQ-039 SHALL cover: FIFO full plus simultaneous RXVERI read and rx pulse -> no overflow and rx_sayi stays 8.
REQ-040 SHALL cover: rstn_i asserted during TX_GONDER -> tx_gecerli_o=0 immediately (asynchronously) and both FIFOs empty.
